cnn_result_writer: RTL and testbench

//  Write-side counterpart of the CNN line-buffer reader: takes the convolution result stream
//  (one 32-bit word per output pixel) and issues lacc write commands to external memory.

---
 rtl/cnn_result_writer_pkg.sv | 24 ++
 rtl/cnn_wb_fifo.sv | 67 ++++++
 rtl/cnn_result_writer.sv | 160 ++++++++++++++++
 tb/tb_cnn_result_writer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_result_writer_pkg.sv
// Shared configuration for the CNN result writer: frame geometry, FSM encodings and width helpers.
// Frame geometry mirrors the line-buffer reader (BUFFER_* / KERNEL_SIZE) so both sides agree.
package cnn_result_writer_pkg;

   localparam int KERNEL_SIZE  = 3;
   localparam int BUFFER_WIDTH = 8;
   localparam int BUFFER_DEPTH = 8;

   localparam int OUT_W_CFG = BUFFER_WIDTH - KERNEL_SIZE + 1;
   localparam int OUT_H_CFG = BUFFER_DEPTH - KERNEL_SIZE + 1;

   localparam int RESULT_W = 32;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Bits needed to hold values 0..n inclusive.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/cnn_wb_fifo.sv
// Synchronous result FIFO with occupancy count, flush and same-cycle push/pop.
// The head entry is visible combinationally so a command can be issued the cycle after a push.
module cnn_wb_fifo
   import cnn_result_writer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = RESULT_W,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             do_push_s;
   logic             do_pop_s;

   // A full FIFO may still accept a push when the head leaves in the same cycle.
   assign do_pop_s  = pop & (count_r != CNT_W'(0));
   assign do_push_s = push & ((count_r != CNT_W'(DEPTH)) | do_pop_s);

   // Pointer and occupancy bookkeeping; flush discards every entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= PTR_W'(0);
         rd_ptr_r <= PTR_W'(0);
         count_r  <= CNT_W'(0);
      end else if (flush) begin
         wr_ptr_r <= PTR_W'(0);
         rd_ptr_r <= PTR_W'(0);
         count_r  <= CNT_W'(0);
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Data storage; contents beyond the count are don't-care, so no reset is needed.
   always_ff @(posedge clk) begin
      if (do_push_s && !flush) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   assign head  = mem_r[rd_ptr_r];
   assign count = count_r;

endmodule

// File: rtl/cnn_result_writer.sv
// Turns the convolution result stream into row-major lacc write commands through a small FIFO,
// back-pressuring the PE array with result_stall and flagging done after the last write.
module cnn_result_writer
   import cnn_result_writer_pkg::*;
#(
   parameter int OUT_W      = OUT_W_CFG,
   parameter int OUT_H      = OUT_H_CFG,
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic                result_valid,
   input  logic [RESULT_W-1:0] result_data,
   output logic                result_stall,
   output logic                lacc_cmd_valid,
   input  logic                lacc_cmd_ready,
   output logic                lacc_cmd_write,
   output logic [ADDR_W-1:0]   lacc_cmd_addr,
   output logic [RESULT_W-1:0] lacc_cmd_wdata,
   output logic                done
);

   localparam int FRAME_WORDS = OUT_W * OUT_H;
   localparam int CNT_W       = cnt_width(FIFO_DEPTH);
   localparam int ACC_W       = cnt_width(FRAME_WORDS);
   localparam int COL_W       = cnt_width(OUT_W);
   localparam int ROW_W       = cnt_width(OUT_H);

   localparam logic [CNT_W-1:0] STALL_LVL = CNT_W'(FIFO_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [ACC_W-1:0] ACC_LAST  = ACC_W'(FRAME_WORDS - 1);
   localparam logic [ACC_W-1:0] ACC_FULL  = ACC_W'(FRAME_WORDS);
   localparam logic [COL_W-1:0] COL_LAST  = COL_W'(OUT_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(OUT_H - 1);

   logic [1:0]          state_r;
   logic [1:0]          state_nxt_s;
   logic [ACC_W-1:0]    accept_cnt_r;
   logic [COL_W-1:0]    col_r;
   logic [ROW_W-1:0]    row_r;
   logic [ADDR_W-1:0]   base_r;
   logic                done_r;

   logic [CNT_W-1:0]    fifo_count_s;
   logic [RESULT_W-1:0] fifo_head_s;
   logic                run_s;
   logic                cmd_valid_s;
   logic                push_s;
   logic                hsk_s;
   logic                last_accept_s;
   logic                last_issue_s;
   logic [ADDR_W-1:0]   word_idx_s;

   // Stall depends only on registered state; one slot of headroom covers the PE's reaction time.
   assign run_s         = (state_r == ST_RUN);
   assign result_stall  = ~run_s | (fifo_count_s >= STALL_LVL);
   assign push_s        = result_valid & ~result_stall;
   assign cmd_valid_s   = (fifo_count_s != CNT_W'(0));
   assign hsk_s         = cmd_valid_s & lacc_cmd_ready;
   assign last_accept_s = push_s & (accept_cnt_r == ACC_LAST);
   assign last_issue_s  = (state_r == ST_DRAIN) & hsk_s & (fifo_count_s == CNT_ONE);

   cnn_wb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (RESULT_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (req),
      .push      (push_s),
      .push_data (result_data),
      .pop       (hsk_s),
      .head      (fifo_head_s),
      .count     (fifo_count_s)
   );

   // Frame sequencing; a req in any state restarts in RUN (handled in the register block).
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            state_nxt_s = ST_IDLE;
         end
         ST_RUN: begin
            if (last_accept_s) begin
               state_nxt_s = ST_DRAIN;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (last_issue_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_DONE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // FSM, accept counter, done flag and latched base address.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         accept_cnt_r <= ACC_W'(0);
         base_r       <= ADDR_W'(0);
         done_r       <= 1'b0;
      end else if (req) begin
         state_r      <= ST_RUN;
         accept_cnt_r <= ACC_W'(0);
         base_r       <= base_addr;
         done_r       <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         if (push_s && (accept_cnt_r != ACC_FULL)) begin
            accept_cnt_r <= accept_cnt_r + ACC_W'(1);
         end
         if (last_issue_s) begin
            done_r <= 1'b1;
         end
      end
   end

   // Row-major issue position, advanced once per accepted write command.
   always_ff @(posedge clk) begin
      if (rst || req) begin
         col_r <= COL_W'(0);
         row_r <= ROW_W'(0);
      end else if (hsk_s) begin
         if (col_r == COL_LAST) begin
            col_r <= COL_W'(0);
            if (row_r == ROW_LAST) begin
               row_r <= ROW_W'(0);
            end else begin
               row_r <= row_r + ROW_W'(1);
            end
         end else begin
            col_r <= col_r + COL_W'(1);
         end
      end
   end

   // Byte address wraps modulo 2^ADDR_W by construction of the fixed-width adder.
   assign word_idx_s     = ADDR_W'(row_r) * ADDR_W'(OUT_W) + ADDR_W'(col_r);
   assign lacc_cmd_addr  = base_r + {word_idx_s[ADDR_W-3:0], 2'b00};
   assign lacc_cmd_wdata = fifo_head_s;
   assign lacc_cmd_valid = cmd_valid_s;
   assign lacc_cmd_write = cmd_valid_s;
   assign done           = done_r;

endmodule

// File: tb/tb_cnn_result_writer.sv
// Scoreboard bench for cnn_result_writer (6x6 output frame): expected commands are queued on
// every accepted beat and checked against the command port until they are handshaken.
module tb_cnn_result_writer;

   localparam int TOTAL = 36;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic [31:0] base_addr = 32'h0;
   logic        result_valid = 1'b0;
   logic [31:0] result_data = 32'h0;
   logic        result_stall;
   logic        lacc_cmd_valid;
   logic        lacc_cmd_ready = 1'b0;
   logic        lacc_cmd_write;
   logic [31:0] lacc_cmd_addr;
   logic [31:0] lacc_cmd_wdata;
   logic        done;

   always #5 clk = ~clk;

   cnn_result_writer dut (
      .clk            (clk),
      .rst            (rst),
      .req            (req),
      .base_addr      (base_addr),
      .result_valid   (result_valid),
      .result_data    (result_data),
      .result_stall   (result_stall),
      .lacc_cmd_valid (lacc_cmd_valid),
      .lacc_cmd_ready (lacc_cmd_ready),
      .lacc_cmd_write (lacc_cmd_write),
      .lacc_cmd_addr  (lacc_cmd_addr),
      .lacc_cmd_wdata (lacc_cmd_wdata),
      .done           (done)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          accepted = 0;
   int          handshakes = 0;
   logic [31:0] exp_base = 32'h0;
   logic        exp_run = 1'b0;
   logic        exp_done = 1'b0;
   logic [31:0] hsk_log [64];

   // One clock cycle, entered and left at a falling edge: drive, check outputs, advance the model.
   task automatic cycle(input logic v, input logic [31:0] d, input logic rdy,
                        input logic rq, input logic [31:0] rq_base, output logic acc);
      logic exp_stall;
      logic exp_valid;
      logic hsk;
      exp_t e;
      result_valid   = v;
      result_data    = d;
      lacc_cmd_ready = rdy;
      req            = rq;
      base_addr      = rq_base;
      #1;
      exp_stall = !exp_run || (sb.size() >= 3);
      exp_valid = (sb.size() != 0);
      vectors++;
      if (result_stall !== exp_stall) begin
         miscompares++;
         $display("FAIL stall: got %b expected %b at %0t", result_stall, exp_stall, $time);
      end
      vectors++;
      if (lacc_cmd_valid !== exp_valid) begin
         miscompares++;
         $display("FAIL cmd_valid: got %b expected %b at %0t", lacc_cmd_valid, exp_valid, $time);
      end
      vectors++;
      if (done !== exp_done) begin
         miscompares++;
         $display("FAIL done: got %b expected %b at %0t", done, exp_done, $time);
      end
      if (lacc_cmd_valid === 1'b1 && sb.size() != 0) begin
         e = sb[0];
         vectors++;
         if (lacc_cmd_addr !== e.addr) begin
            miscompares++;
            $display("FAIL cmd_addr: got %h expected %h at %0t", lacc_cmd_addr, e.addr, $time);
         end
         vectors++;
         if (lacc_cmd_wdata !== e.data) begin
            miscompares++;
            $display("FAIL cmd_wdata: got %h expected %h at %0t", lacc_cmd_wdata, e.data, $time);
         end
         vectors++;
         if (lacc_cmd_write !== 1'b1) begin
            miscompares++;
            $display("FAIL cmd_write: got %b expected 1 at %0t", lacc_cmd_write, $time);
         end
      end
      acc = 1'b0;
      if (rq) begin
         sb.delete();
         accepted   = 0;
         handshakes = 0;
         exp_base   = rq_base;
         exp_run    = 1'b1;
         exp_done   = 1'b0;
      end else begin
         hsk = (lacc_cmd_valid === 1'b1) && rdy;
         if (hsk) begin
            if (handshakes < 64) hsk_log[handshakes] = lacc_cmd_addr;
            handshakes++;
            if (sb.size() != 0) void'(sb.pop_front());
            if (!exp_run && sb.size() == 0 && accepted == TOTAL) exp_done = 1'b1;
         end
         if (v && !exp_stall) begin
            acc = 1'b1;
            sb.push_back({exp_base + 32'(accepted) * 32'd4, d});
            accepted++;
            if (accepted == TOTAL) exp_run = 1'b0;
         end
      end
      @(negedge clk);
      req = 1'b0;
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      req            = 1'b0;
      result_valid   = 1'b0;
      lacc_cmd_ready = 1'b0;
      @(negedge clk);
      vectors++;
      if (lacc_cmd_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_cmd_valid: got %b expected 0", lacc_cmd_valid);
      end
      vectors++;
      if (result_stall !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_stall: got %b expected 1", result_stall);
      end
      vectors++;
      if (done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_done: got %b expected 0", done);
      end
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      accepted   = 0;
      handshakes = 0;
      exp_run    = 1'b0;
      exp_done   = 1'b0;
   endtask

   // Offer beats (data = seed + index) until stop_hsk handshakes; optionally hold ready low once.
   task automatic feed(input int stop_hsk, input int hold_at, input int hold_len,
                       input logic keep_valid, input logic [31:0] seed);
      int   i = 0;
      int   held = 0;
      int   guard = 0;
      logic rdy;
      logic v;
      logic acc;
      while (handshakes < stop_hsk && guard < 1000) begin
         if (handshakes == hold_at && held < hold_len) begin
            rdy = 1'b0;
            held++;
         end else begin
            rdy = 1'b1;
         end
         v = keep_valid || (i < TOTAL);
         cycle(v, seed + 32'(i), rdy, 1'b0, 32'h0, acc);
         if (acc) i++;
         guard++;
      end
      vectors++;
      if (handshakes < stop_hsk) begin
         miscompares++;
         $display("FAIL feed_timeout: got %0d handshakes expected %0d", handshakes, stop_hsk);
      end
   endtask

   task automatic check_log(input string name, input int idx, input logic [31:0] exp);
      vectors++;
      if (hsk_log[idx] !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, hsk_log[idx], exp);
      end
   endtask

   task automatic test_reset();
      logic acc;
      do_reset();
      for (int k = 0; k < 3; k++) cycle(1'b1, 32'hDEAD_0000 + 32'(k), 1'b1, 1'b0, 32'h0, acc);
   endtask

   task automatic test_full_frame();
      logic acc;
      cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_1000, acc);
      feed(TOTAL, -1, 0, 1'b0, 32'hA000_0000);
      check_log("frame_first_addr", 0, 32'h0000_1000);
      check_log("frame_last_addr", 35, 32'h0000_108C);
      for (int k = 0; k < 4; k++) cycle(k[0], 32'h0, 1'b1, 1'b0, 32'h0, acc);
   endtask

   task automatic test_ready_hold();
      logic acc;
      cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_1800, acc);
      feed(TOTAL, 5, 10, 1'b0, 32'hB000_0000);
      check_log("hold_last_addr", 35, 32'h0000_188C);
   endtask

   task automatic test_row_wrap();
      logic acc;
      cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_2000, acc);
      feed(TOTAL, -1, 0, 1'b0, 32'hC000_0000);
      check_log("row0_col5_addr", 5, 32'h0000_2014);
      check_log("row1_col0_addr", 6, 32'h0000_2018);
   endtask

   task automatic test_restart();
      logic acc;
      cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_3000, acc);
      feed(10, -1, 0, 1'b0, 32'h3300_0000);
      cycle(1'b1, 32'h3333_3333, 1'b1, 1'b1, 32'h0000_4000, acc);
      feed(TOTAL, -1, 0, 1'b0, 32'h4400_0000);
      check_log("restart_first_addr", 0, 32'h0000_4000);
      check_log("restart_last_addr", 35, 32'h0000_408C);
   endtask

   task automatic test_saturate_wrap();
      logic acc;
      cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFF0, acc);
      feed(TOTAL, -1, 0, 1'b1, 32'h5500_0000);
      check_log("wrap_pre_addr", 3, 32'hFFFF_FFFC);
      check_log("wrap_zero_addr", 4, 32'h0000_0000);
      for (int k = 0; k < 8; k++) cycle(1'b1, 32'h5555_0000 + 32'(k), 1'b1, 1'b0, 32'h0, acc);
      vectors++;
      if (handshakes != TOTAL) begin
         miscompares++;
         $display("FAIL extra_commands: got %0d handshakes expected %0d", handshakes, TOTAL);
      end
   endtask

   task automatic test_reset_drain();
      logic acc;
      int   guard = 0;
      cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_5000, acc);
      while (accepted < TOTAL && guard < 200) begin
         cycle(1'b1, 32'hD000_0000 + 32'(accepted), 1'b1, 1'b0, 32'h0, acc);
         guard++;
      end
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, acc);
      vectors++;
      if (lacc_cmd_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL drain_pending: got %b expected 1", lacc_cmd_valid);
      end
      do_reset();
      for (int k = 0; k < 2; k++) cycle(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, acc);
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_ready_hold();
      test_row_wrap();
      test_restart();
      test_saturate_wrap();
      test_reset_drain();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
